// File: rtl/rv_fetch_unit.sv
// Instruction fetch stage: one outstanding word request to memory, a small
// {pc, instr} buffer toward decode, and redirect handling with in-flight kill.
package rv_pkg;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
endpackage

module rv_fetch_unit
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0001_0094,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic [XLEN-1:0] instr_addr_o,
    output logic            instr_valid_o,
    input  logic [ILEN-1:0] instr_rdata_i,
    input  logic            instr_ready_i,
    output logic            fetch_valid_o,
    input  logic            fetch_ready_i,
    output logic [XLEN-1:0] fetch_pc_o,
    output logic [ILEN-1:0] fetch_instr_o,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [1:0]      dbg_state_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            valid_q, valid_d;
    logic            kill_q, kill_d;

    logic [XLEN-1:0] pc_mem_q    [FIFO_DEPTH];
    logic [ILEN-1:0] instr_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic            push, pop, has_room;
    logic [XLEN-1:0] redirect_tgt, issue_pc;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        valid_d      = valid_q;
        kill_d       = kill_q;
        push         = 1'b0;
        redirect_tgt = redirect_pc_i & ~XLEN'(3);
        // A redirect in IDLE issues straight to the new target; the buffer is being cleared.
        issue_pc     = redirect_i ? redirect_tgt : pc_q;
        has_room     = redirect_i || (count_q < CNT_W'(FIFO_DEPTH));
        pop          = fetch_valid_o & fetch_ready_i & ~redirect_i;

        if (redirect_i) begin
            pc_d = redirect_tgt;
        end

        case (state_q)
            S_IDLE: begin
                if (has_room) begin
                    state_d = S_REQ;
                    valid_d = 1'b1;
                    addr_d  = issue_pc >> 2;
                end
            end
            S_REQ: begin
                if (instr_ready_i) begin
                    state_d = S_GAP;
                    valid_d = 1'b0;
                    kill_d  = 1'b0;
                    if (!kill_q && !redirect_i) begin
                        push = 1'b1;
                        pc_d = pc_q + XLEN'(4);
                    end
                end else if (redirect_i) begin
                    // The memory request cannot be withdrawn, so its response is dropped later.
                    kill_d = 1'b1;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC >> 2;
            valid_q  <= 1'b0;
            kill_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            kill_q  <= kill_d;
            if (redirect_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    pc_mem_q[wr_ptr_q]    <= pc_q;
                    instr_mem_q[wr_ptr_q] <= instr_rdata_i;
                    wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    assign instr_addr_o  = addr_q;
    assign instr_valid_o = valid_q;
    assign fetch_valid_o = (count_q != '0);
    assign fetch_pc_o    = pc_mem_q[rd_ptr_q];
    assign fetch_instr_o = instr_mem_q[rd_ptr_q];
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Bench for rv_fetch_unit: a queue-based fetch model checked every cycle,
// directed scenarios with literal expectations, then a randomised stream.
module tb_rv_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0001_0094;
    localparam int          DEPTH    = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst          = 1'b1;
    logic [31:0] instr_rdata  = '0;
    logic        instr_ready  = 1'b0;
    logic        fetch_ready  = 1'b0;
    logic        redirect     = 1'b0;
    logic [31:0] redirect_pc  = '0;

    logic [31:0] instr_addr_o;
    logic        instr_valid_o;
    logic        fetch_valid_o;
    logic [31:0] fetch_pc_o;
    logic [31:0] fetch_instr_o;
    logic [1:0]  dbg_state_o;

    rv_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .instr_addr_o  (instr_addr_o),
        .instr_valid_o (instr_valid_o),
        .instr_rdata_i (instr_rdata),
        .instr_ready_i (instr_ready),
        .fetch_valid_o (fetch_valid_o),
        .fetch_ready_i (fetch_ready),
        .fetch_pc_o    (fetch_pc_o),
        .fetch_instr_o (fetch_instr_o),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .dbg_state_o   (dbg_state_o)
    );

    // ---------------- scoreboard / model ----------------
    int   n_vec  = 0;
    int   n_err  = 0;
    bit   chk_en = 1'b0;

    logic [63:0] exp_q[$];        // {pc, instr} entries decode should see, head first
    logic [31:0] m_pc, m_addr;
    bit          m_req, m_gap, m_kill;
    int          m_sz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a request is outstanding until answered; after each answer the port
    // must rest two edges before the next request may go out, and only with room.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_pc   = RESET_PC;
            m_addr = RESET_PC >> 2;
            m_req  = 1'b0;
            m_gap  = 1'b0;
            m_kill = 1'b0;
        end else begin
            m_sz = exp_q.size();
            if (redirect) begin
                exp_q.delete();
                m_pc = redirect_pc & ~32'd3;
                if (m_req) begin
                    if (instr_ready) begin
                        m_req  = 1'b0;
                        m_gap  = 1'b1;
                        m_kill = 1'b0;
                    end else begin
                        m_kill = 1'b1;
                    end
                end else if (m_gap) begin
                    m_gap = 1'b0;
                end else begin
                    m_req  = 1'b1;
                    m_addr = m_pc >> 2;
                end
            end else begin
                if (m_sz > 0 && fetch_ready) void'(exp_q.pop_front());
                if (m_req) begin
                    if (instr_ready) begin
                        m_req = 1'b0;
                        m_gap = 1'b1;
                        if (m_kill) begin
                            m_kill = 1'b0;
                        end else begin
                            exp_q.push_back({m_pc, instr_rdata});
                            m_pc = m_pc + 32'd4;
                        end
                    end
                end else if (m_gap) begin
                    m_gap = 1'b0;
                end else if (m_sz < DEPTH) begin
                    m_req  = 1'b1;
                    m_addr = m_pc >> 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("instr_valid", 32'(instr_valid_o), 32'(m_req));
            check("instr_addr", instr_addr_o, m_addr);
            check("fetch_valid", 32'(fetch_valid_o), 32'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                check("fetch_pc", fetch_pc_o, exp_q[0][63:32]);
                check("fetch_instr", fetch_instr_o, exp_q[0][31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_req(input bit jitter);
        int i;
        i = 0;
        while (instr_valid_o !== 1'b1 && i < 40) begin
            if (jitter) fetch_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            i++;
        end
        check("req_wait", 32'(instr_valid_o), 32'd1);
    endtask

    task automatic respond(input logic [31:0] data);
        instr_ready = 1'b1;
        instr_rdata = data;
        @(negedge clk);
        instr_ready = 1'b0;
    endtask

    task automatic pulse_redirect(input logic [31:0] tgt);
        redirect    = 1'b1;
        redirect_pc = tgt;
        @(negedge clk);
        redirect    = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_addr", instr_addr_o, 32'h0000_4025);
        check("rst_fvalid", 32'(fetch_valid_o), 32'd0);
        check("rst_fpc", fetch_pc_o, 32'd0);
        check("rst_finstr", fetch_instr_o, 32'd0);

        rst = 1'b0;
        @(negedge clk);
        check("first_valid", 32'(instr_valid_o), 32'd1);
        check("first_addr", instr_addr_o, 32'h0000_4025);

        repeat (3) @(negedge clk);
        respond(32'h0000_0013);
        check("lat_fvalid", 32'(fetch_valid_o), 32'd1);
        check("lat_fpc", fetch_pc_o, 32'h0001_0094);
        check("lat_finstr", fetch_instr_o, 32'h0000_0013);
        check("lat_valid_lo", 32'(instr_valid_o), 32'd0);
        @(negedge clk);
        check("gap_valid_lo", 32'(instr_valid_o), 32'd0);
        @(negedge clk);
        check("second_valid", 32'(instr_valid_o), 32'd1);
        check("second_addr", instr_addr_o, 32'h0000_4026);

        // Backpressure: buffer fills, port stays quiet until a pop.
        respond(32'h0010_0093);
        repeat (6) @(negedge clk);
        check("full_stall", 32'(instr_valid_o), 32'd0);
        check("full_head", fetch_pc_o, 32'h0001_0094);
        fetch_ready = 1'b1;
        @(negedge clk);
        fetch_ready = 1'b0;
        check("pop_head_pc", fetch_pc_o, 32'h0001_0098);
        check("pop_head_in", fetch_instr_o, 32'h0010_0093);
        wait_req(1'b0);
        check("after_pop_addr", instr_addr_o, 32'h0000_4027);

        // Redirect with a request pending: response is killed.
        pulse_redirect(32'h0001_0200);
        check("kill_fvalid", 32'(fetch_valid_o), 32'd0);
        check("kill_hold", instr_addr_o, 32'h0000_4027);
        repeat (2) @(negedge clk);
        respond(32'hdead_beef);
        check("kill_drop", 32'(fetch_valid_o), 32'd0);
        wait_req(1'b0);
        check("redir_addr", instr_addr_o, 32'h0000_4080);
        respond(32'h0000_0033);
        check("redir_pc", fetch_pc_o, 32'h0001_0200);
        check("redir_instr", fetch_instr_o, 32'h0000_0033);
        fetch_ready = 1'b1;

        // Redirect coinciding with the response.
        wait_req(1'b0);
        check("seq_addr", instr_addr_o, 32'h0000_4081);
        redirect    = 1'b1;
        redirect_pc = 32'h0001_0203;
        instr_ready = 1'b1;
        instr_rdata = 32'h1111_1111;
        @(negedge clk);
        redirect    = 1'b0;
        instr_ready = 1'b0;
        check("same_valid", 32'(instr_valid_o), 32'd0);
        check("same_fvalid", 32'(fetch_valid_o), 32'd0);
        wait_req(1'b0);
        check("same_addr", instr_addr_o, 32'h0000_4080);
        respond(32'h2222_2222);
        check("same_pc", fetch_pc_o, 32'h0001_0200);

        // Reset in the middle of a request; a late ready is ignored.
        wait_req(1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 32'(instr_valid_o), 32'd0);
        check("mid_rst_addr", instr_addr_o, 32'h0000_4025);
        instr_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        instr_ready = 1'b0;
        check("restart_valid", 32'(instr_valid_o), 32'd1);
        check("restart_addr", instr_addr_o, 32'h0000_4025);
        check("restart_fvalid", 32'(fetch_valid_o), 32'd0);

        // PC wrap at the top of the address space.
        pulse_redirect(32'hffff_fffe);
        @(negedge clk);
        respond(32'h0);
        check("wrap_kill", 32'(fetch_valid_o), 32'd0);
        wait_req(1'b0);
        check("wrap_addr_top", instr_addr_o, 32'h3fff_ffff);
        respond(32'h0000_0055);
        check("wrap_pc", fetch_pc_o, 32'hffff_fffc);
        wait_req(1'b0);
        check("wrap_addr_zero", instr_addr_o, 32'h0000_0000);

        // Random stream: variable latency, backpressure, occasional redirects.
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 5) == 0) pulse_redirect($urandom);
            wait_req(1'b1);
            repeat ($urandom_range(0, 3)) begin
                fetch_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            fetch_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                redirect    = 1'b1;
                redirect_pc = $urandom;
            end
            respond($urandom);
            redirect = 1'b0;
        end
        fetch_ready = 1'b1;
        repeat (8) @(negedge clk);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
